dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Memory-mapped I/O responder on the processor's dmem port, the memory side of the processor's load/store interface.
- Decodes a 16-word window at the top of the 12-bit dmem address space and serves loads/stores with syncram-identical timing: one-cycle registered read data.
- Provides a cycle counter, a countdown timer with interrupt, four scratch registers, and a byte TX FIFO drained by a valid/ready consumer.
- The top level muxes `q` over `q_dmem` when `hit` was asserted on the previous cycle.

Parameters:
- BASE_ADDR, 12'hF00, window base; only bits [11:4] compared.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  12  dmem word address from processor.
- data  input  32  store data.
- wren  input  1  store enable.
- q  output  32  load data, registered.
- hit  output  1  combinational, 1 when address[11:4]==BASE_ADDR[11:4].
- irq  output  1  timer interrupt, registered.
- out_data  output  8  FIFO head byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head.

Behaviour:
- Reset (reset==0, async):
  - q=0, irq=0, out_valid=0, out_data=0.
  - All registers 0, FIFO emptied, count 0.
  - Applies immediately mid-operation, including mid-drain.
- Register map, offset=address[3:0]:
  - 0x0 CYCLE, RO: +1 every clock, wraps 0xFFFFFFFF->0.
  - 0x1 TIMER_LOAD, RW: a write also loads TIMER_VAL=data the same edge.
  - 0x2 TIMER_VAL, RO.
  - 0x3 TIMER_CTRL, RW: bit0 enable, bit1 auto-reload, bit2 irq_en; other bits read 0.
  - 0x4 STATUS:
    - bit0 expired, sticky, W1C.
    - bit1 full, bit2 empty.
    - bit3 overflow, sticky, W1C.
    - bits[7:4] FIFO count.
    - Other bits 0.
  - 0x5 TX_DATA, WO: write pushes data[7:0]; reads 0.
  - 0x8-0xB SCRATCH0-3, RW, full 32 bits.
  - All other offsets read 0; writes ignored.
- Write/read gating:
  - Writes take effect only when wren & hit.
  - Writes to RO offsets are ignored.
- Read timing:
  - q <= value(address) at every rising edge when hit, else q <= 0.
  - Latency is exactly 1 cycle; a store and a load at the same address in the same cycle return the pre-write value.
- Timer (each edge, enable=1):
  - If VAL>1: VAL-1.
  - If VAL==1: VAL<=0 and expired<=1.
  - If VAL==0: if auto-reload and LOAD!=0, VAL<=LOAD; else hold.
  - enable=0 holds VAL.
  - A TIMER_LOAD write overrides decrement in the same cycle.
  - Expiry and a W1C of expired in the same cycle: set wins.
- irq <= expired & irq_en.
- FIFO:
  - out_data = head; out_valid = count!=0.
  - Pop when out_valid & out_ready.
  - Push when not full, or when full and popping the same cycle (count unchanged).
  - Push when full without pop: byte dropped, overflow<=1.
  - Push+pop when empty: push only, since out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- MMIO_TIMER_EN defined: timer, TIMER_* registers, STATUS bit0 and irq exist as above.
- MMIO_TIMER_EN undefined:
  - Timer logic is absent.
  - Offsets 0x1-0x3 read 0 and ignore writes.
  - STATUS bit0 reads 0; irq tied to 0.
  - All other behaviour is unchanged.

Test Plan:
- Release reset, read 0xF00 twice 5 cycles apart -> second value minus first equals 5; read 0xF04 -> 0x00000004 (empty=1).
- Write SCRATCH2 (0xF0A)=0xDEADBEEF, read next cycle -> q=0xDEADBEEF one edge after address presented; read 0xF0F -> 0; read address 0x100 -> hit=0, q=0.
- TIMER_LOAD=3, CTRL=0x5 -> VAL 2,1,0, expired set on third edge, irq=1 one edge later; write STATUS=0x1 -> expired and irq clear; with CTRL=0x7 VAL reloads to 3 after reaching 0.
- out_ready=0, push 9 bytes 0x01..0x09 (depth 8) -> count 8, full=1, overflow=1, 0x09 lost; out_ready=1 -> out_data 0x01..0x08 in order, then out_valid=0.
- FIFO full, push 0xAA with out_ready=1 same cycle -> count stays 8, no overflow, 0xAA drained last.
- Assert reset mid-drain with count 5 and VAL 10 -> q, irq, out_valid drop to 0 immediately; after release count=0, CYCLE restarts at 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the dmem port: cycle counter, scratch registers, byte TX FIFO.
// Define MMIO_TIMER_EN to include the countdown timer, its registers and irq.
module dmem_mmio_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hF00,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_TLOAD  = 4'h1;
  localparam logic [3:0] OFF_TVAL   = 4'h2;
  localparam logic [3:0] OFF_TCTRL  = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TX     = 4'h5;

  logic [3:0]    off;
  logic          wr_en;
  logic [31:0]   cycle;
  logic [31:0]   scratch [4];
  logic [31:0]   rd_val;
  logic          expired;
  logic          overflow;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    count_ext;
  logic          full, empty, pop, push_req, do_push;

  assign hit   = (address[11:4] == BASE_ADDR[11:4]);
  assign off   = address[3:0];
  assign wr_en = wren & hit;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign count_ext = 5'(count);
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  assign push_req  = wr_en && (off == OFF_TX);
  // A push into a full FIFO still lands when the head leaves on the same edge
  assign do_push   = push_req && (!full || pop);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_load, timer_val;
  logic [2:0]  timer_ctrl;
  logic        load_wr, expire_now;

  assign load_wr    = wr_en && (off == OFF_TLOAD);
  assign expire_now = timer_ctrl[0] && !load_wr && (timer_val == 32'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_load <= '0;
      timer_val  <= '0;
      timer_ctrl <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (load_wr) begin
        timer_load <= data;
        timer_val  <= data;
      end else if (timer_ctrl[0]) begin
        if (timer_val > 32'd1)
          timer_val <= timer_val - 32'd1;
        else if (timer_val == 32'd1)
          timer_val <= '0;
        else if (timer_ctrl[1] && timer_load != '0)
          timer_val <= timer_load;
      end
      if (wr_en && off == OFF_TCTRL)
        timer_ctrl <= data[2:0];
      if (expire_now)
        expired <= 1'b1;
      else if (wr_en && off == OFF_STATUS && data[0])
        expired <= 1'b0;
      irq <= expired & timer_ctrl[2];
    end
  end
`else
  assign expired = 1'b0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CYCLE:  rd_val = cycle;
`ifdef MMIO_TIMER_EN
      OFF_TLOAD:  rd_val = timer_load;
      OFF_TVAL:   rd_val = timer_val;
      OFF_TCTRL:  rd_val = {29'd0, timer_ctrl};
`endif
      OFF_STATUS: rd_val = {24'd0, count_ext[3:0], overflow, empty, full, expired};
      4'h8, 4'h9, 4'hA, 4'hB: rd_val = scratch[off[1:0]];
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q        <= '0;
      cycle    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < 4; i++)
        scratch[i] <= '0;
    end else begin
      q     <= hit ? rd_val : '0;
      cycle <= cycle + 32'd1;
      if (wr_en && off[3:2] == 2'b10)
        scratch[off[1:0]] <= data;
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (wr_en && off == OFF_STATUS && data[3])
        overflow <= 1'b0;
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      fifo_mem[wr_ptr] <= data[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: load results and drained bytes are
// queued by the stimulus and checked by independent negedge monitors.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic        hit, irq, out_valid;
  logic [7:0]  out_data;

  dmem_mmio_responder #(.BASE_ADDR(12'hF00), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data), .wren(wren),
    .q(q), .hit(hit), .irq(irq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q [$];
  logic [7:0]  exp_fifo [$];
  logic        rd_issue = 1'b0;
  logic        rd_seen = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clock or negedge reset)
    if (!reset) rd_seen <= 1'b0;
    else        rd_seen <= rd_issue;

  // load-data monitor
  always @(negedge clock) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL q_unexpected: got %h with no expected load queued", q);
      end else begin
        check("q", q, sb_q.pop_front());
      end
    end
  end

  // TX stream monitor: handshake completes on the coming rising edge
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_fifo.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %h with no expected byte queued", out_data);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_fifo.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    address = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp);
    address = a; wren = 1'b0; rd_issue = 1'b1;
    sb_q.push_back(exp);
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    wr(12'hF05, {24'hA5A5A5, b});
    if (accepted) exp_fifo.push_back(b);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    out_ready = 1'b0;
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_left", exp_fifo.size(), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_q", q, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    #10 reset = 1'b1;

    // cycle counter, RO write ignored
    rd(12'hF00, 32'd0);
    repeat (4) tick();
    rd(12'hF00, 32'd5);
    wr(12'hF00, 32'h12345678);
    rd(12'hF00, 32'd7);
    rd(12'hF04, 32'h4);

    // scratch, decode, unmapped offsets
    wr(12'hF0A, 32'hDEADBEEF);
    address = 12'hF0A; #1 check("hit_in", {31'd0, hit}, 32'd1);
    rd(12'hF0A, 32'hDEADBEEF);
    rd(12'hF0F, 32'd0);
    address = 12'h100; #1 check("hit_out", {31'd0, hit}, 32'd0);
    rd(12'h100, 32'd0);
    wr(12'h10A, 32'h5);
    rd(12'hF0A, 32'hDEADBEEF);
    wr(12'hF0C, 32'hFFFFFFFF);
    rd(12'hF0C, 32'd0);
    rd(12'hF05, 32'd0);
    wr(12'hF09, 32'h11111111);
    address = 12'hF09; data = 32'h22222222; wren = 1'b1; rd_issue = 1'b1;
    sb_q.push_back(32'h11111111);
    tick();
    wren = 1'b0; rd_issue = 1'b0;
    rd(12'hF09, 32'h22222222);

`ifdef MMIO_TIMER_EN
    wr(12'hF01, 32'd3);
    wr(12'hF03, 32'h5);
    rd(12'hF02, 32'd3);
    rd(12'hF02, 32'd2);
    rd(12'hF02, 32'd1);
    rd(12'hF04, 32'h5);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(12'hF04, 32'h1);
    rd(12'hF04, 32'h4);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd(12'hF02, 32'd0);
    wr(12'hF03, 32'hFFFFFFF7);
    rd(12'hF02, 32'd0);
    rd(12'hF02, 32'd3);
    rd(12'hF03, 32'h7);
    wr(12'hF03, 32'h0);
    wr(12'hF04, 32'h1);
    rd(12'hF04, 32'h4);
`else
    wr(12'hF01, 32'd3);
    wr(12'hF03, 32'h7);
    rd(12'hF01, 32'd0);
    rd(12'hF02, 32'd0);
    rd(12'hF03, 32'd0);
    repeat (3) tick();
    rd(12'hF04, 32'h4);
    check("irq_tied", {31'd0, irq}, 32'd0);
`endif

    // overflow: 9th byte dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8);
    rd(12'hF04, 32'h8A);
    wr(12'hF04, 32'h8);
    rd(12'hF04, 32'h82);
    drain();
    rd(12'hF04, 32'h4);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
    out_ready = 1'b1;
    push_byte(8'hAA, 1'b1);
    out_ready = 1'b0;
    rd(12'hF04, 32'h82);
    drain();

    // push while empty with ready high
    out_ready = 1'b1;
    push_byte(8'h5A, 1'b1);
    drain();

    // reset mid-drain
`ifdef MMIO_TIMER_EN
    wr(12'hF01, 32'd1);
    wr(12'hF03, 32'h5);
    tick();
    wr(12'hF03, 32'h4);
    wr(12'hF01, 32'd10);
`endif
    for (int i = 0; i < 7; i++) push_byte(8'h31 + 8'(i), 1'b1);
    out_ready = 1'b1;
    tick();
    rd(12'hF0A, 32'hDEADBEEF);
    @(negedge clock);
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
`ifdef MMIO_TIMER_EN
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
`endif
    reset = 1'b0;
    #1;
    check("mid_rst_q", q, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
    exp_fifo.delete();
    sb_q.delete();
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    rd(12'hF00, 32'd0);
    rd(12'hF04, 32'h4);
`ifdef MMIO_TIMER_EN
    rd(12'hF02, 32'd0);
`endif

    repeat (2) tick();
    check("sb_left", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit exceeded");
  end

endmodule
